// File: rtl/transport_rx.sv
// Receive-side decoder for the switch-code transport bus: qualifies stable codes, flags malformed values.
// Optional `define TRANSPORT_RX_ERR_CNT_EN adds a saturating err_cnt output.
module transport_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             clr,
  output logic [3:0]       code,
  output logic [7:0]       onehot,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
`ifdef TRANSPORT_RX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_LOCK} state_t;

  state_t           r_state, w_state_next;
  logic [7:0]       r_data_q;
  logic [3:0]       r_cand, w_cand_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [3:0]       r_code, w_code_next;
  logic [7:0]       r_onehot, w_onehot_next;
  logic             r_valid, w_valid_next;
  logic             r_locked, w_locked_next;
  logic             r_err, w_err_next;
  logic [CNT_W-1:0] r_chg_cnt;
  logic             w_accept;

  logic w_zero, w_good, w_bad, w_same, w_last;
  logic [7:0] w_cand_onehot;

  assign w_zero        = (r_data_q == 8'h00);
  assign w_good        = (r_data_q[7:4] == 4'd0) && (r_data_q[3:0] >= 4'd1) && (r_data_q[3:0] <= 4'd8);
  assign w_bad         = !w_zero && !w_good;
  assign w_same        = (r_data_q[3:0] == r_cand);
  assign w_last        = (r_cnt == 8'(STABLE_CYCLES - 1));
  assign w_cand_onehot = 8'd1 << (r_cand - 4'd1);

  always_comb begin
    w_state_next  = r_state;
    w_cand_next   = r_cand;
    w_cnt_next    = r_cnt;
    w_code_next   = r_code;
    w_onehot_next = r_onehot;
    w_valid_next  = 1'b0;
    w_locked_next = r_locked;
    w_err_next    = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_good) begin
          w_cand_next  = r_data_q[3:0];
          w_cnt_next   = 8'd1;
          w_state_next = S_QUAL;
        end else if (w_bad) begin
          w_err_next = 1'b1;
        end
      end
      S_QUAL: begin
        if (w_good && w_same && w_last) begin
          w_accept      = 1'b1;
          w_valid_next  = 1'b1;
          w_locked_next = 1'b1;
          w_code_next   = r_cand;
          w_onehot_next = w_cand_onehot;
          w_state_next  = S_LOCK;
        end else if (w_good && w_same) begin
          w_cnt_next = r_cnt + 8'd1;
        end else if (w_good) begin
          w_cand_next = r_data_q[3:0];
          w_cnt_next  = 8'd1;
        end else begin
          w_err_next   = w_bad;
          w_state_next = S_IDLE;
        end
      end
      S_LOCK: begin
        if (w_good && !w_same) begin
          w_cand_next   = r_data_q[3:0];
          w_cnt_next    = 8'd1;
          w_locked_next = 1'b0;
          w_state_next  = S_QUAL;
        end else if (!w_good) begin
          w_locked_next = 1'b0;
          w_err_next    = w_bad;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_data_q  <= 8'h00;
      r_cand    <= 4'd0;
      r_cnt     <= 8'd0;
      r_code    <= 4'd0;
      r_onehot  <= 8'h00;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_data_q  <= data;
      r_cand    <= w_cand_next;
      r_cnt     <= w_cnt_next;
      r_code    <= w_code_next;
      r_onehot  <= w_onehot_next;
      r_valid   <= w_valid_next;
      r_locked  <= w_locked_next;
      r_err     <= w_err_next;
    end
  end

  // Only acceptances that change the held code count; clr overrides an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chg_cnt <= '0;
    end else if (clr) begin
      r_chg_cnt <= '0;
    end else if (w_accept && (r_cand != r_code) && (r_chg_cnt != '1)) begin
      r_chg_cnt <= r_chg_cnt + CNT_W'(1);
    end
  end

`ifdef TRANSPORT_RX_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
    end else if (w_err_next && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign code    = r_code;
  assign onehot  = r_onehot;
  assign valid   = r_valid;
  assign locked  = r_locked;
  assign err     = r_err;
  assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_transport_rx.sv
// Directed vector bench for transport_rx: table of per-edge expectations plus hand-written corner sequences.
module tb_transport_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       clr;
  logic [3:0] code;
  logic [7:0] onehot;
  logic       valid, locked, err;
  logic [7:0] chg_cnt;

  logic [7:0] b_data;
  logic       b_clr;
  logic [3:0] b_code;
  logic [7:0] b_onehot;
  logic       b_valid, b_locked, b_err;
  logic [1:0] b_chg_cnt;

`ifdef TRANSPORT_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic [1:0] b_err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  transport_rx #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .data(data), .clr(clr),
    .code(code), .onehot(onehot), .valid(valid), .locked(locked), .err(err),
    .chg_cnt(chg_cnt)
`ifdef TRANSPORT_RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  transport_rx #(.STABLE_CYCLES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .data(b_data), .clr(b_clr),
    .code(b_code), .onehot(b_onehot), .valid(b_valid), .locked(b_locked), .err(b_err),
    .chg_cnt(b_chg_cnt)
`ifdef TRANSPORT_RX_ERR_CNT_EN
    , .err_cnt(b_err_cnt)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       clr;
    logic [3:0] code;
    logic [7:0] onehot;
    logic       valid;
    logic       locked;
    logic       err;
    logic [7:0] chg;
    logic [7:0] errc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] d, input logic c, input logic [3:0] cd, input logic [7:0] oh,
                     input logic v, input logic l, input logic e, input logic [7:0] ch, input logic [7:0] ec);
    vec_t t;
    t.data = d; t.clr = c; t.code = cd; t.onehot = oh; t.valid = v;
    t.locked = l; t.err = e; t.chg = ch; t.errc = ec;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int b_valids;

  task automatic b_hold(input logic [7:0] v, input int n);
    b_data = v;
    for (int k = 0; k < n; k++) begin
      step();
      if (b_valid) b_valids++;
    end
  endtask

  initial begin
    rst = 1'b0; data = 8'h00; clr = 1'b0; b_data = 8'h00; b_clr = 1'b0;

    // data, clr, code, onehot, valid, locked, err, chg, err_cnt (expected after the edge)
    for (int i = 0; i < 4; i++) add(8'h05, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add(8'h05, 0, 5, 8'h10, 1, 1, 0, 1, 0);
    add(8'h05, 0, 5, 8'h10, 0, 1, 0, 1, 0);
    add(8'h03, 0, 5, 8'h10, 0, 1, 0, 1, 0);
    add(8'h03, 0, 5, 8'h10, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(8'h07, 0, 5, 8'h10, 0, 0, 0, 1, 0);
    add(8'h07, 0, 7, 8'h40, 1, 1, 0, 2, 0);
    add(8'h02, 0, 7, 8'h40, 0, 1, 0, 2, 0);
    for (int i = 0; i < 3; i++) add(8'h02, 0, 7, 8'h40, 0, 0, 0, 2, 0);
    add(8'h02, 0, 2, 8'h02, 1, 1, 0, 3, 0);
    add(8'h00, 0, 2, 8'h02, 0, 1, 0, 3, 0);
    for (int i = 0; i < 2; i++) add(8'h00, 0, 2, 8'h02, 0, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) add(8'h02, 0, 2, 8'h02, 0, 0, 0, 3, 0);
    add(8'h02, 0, 2, 8'h02, 1, 1, 0, 3, 0);
    add(8'h04, 0, 2, 8'h02, 0, 1, 0, 3, 0);
    for (int i = 0; i < 3; i++) add(8'h04, 0, 2, 8'h02, 0, 0, 0, 3, 0);
    add(8'h04, 0, 4, 8'h08, 1, 1, 0, 4, 0);
    add(8'h14, 0, 4, 8'h08, 0, 1, 0, 4, 0);
    add(8'h09, 0, 4, 8'h08, 0, 0, 1, 4, 1);
    add(8'h00, 0, 4, 8'h08, 0, 0, 1, 4, 2);
    add(8'h00, 0, 4, 8'h08, 0, 0, 0, 4, 2);
    add(8'h00, 1, 4, 8'h08, 0, 0, 0, 0, 0);

    step();
    step();
    chk("reset_code", 32'(code), 0);
    chk("reset_onehot", 32'(onehot), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_chg", 32'(chg_cnt), 0);
    rst = 1'b1;

    foreach (vq[i]) begin
      data = vq[i].data;
      clr  = vq[i].clr;
      step();
      $display("row %0d data=%02h clr=%0b code=%0d onehot=%02h valid=%0b locked=%0b err=%0b chg=%0d",
               i, vq[i].data, vq[i].clr, code, onehot, valid, locked, err, chg_cnt);
      chk($sformatf("row%0d_code", i), 32'(code), 32'(vq[i].code));
      chk($sformatf("row%0d_onehot", i), 32'(onehot), 32'(vq[i].onehot));
      chk($sformatf("row%0d_valid", i), 32'(valid), 32'(vq[i].valid));
      chk($sformatf("row%0d_locked", i), 32'(locked), 32'(vq[i].locked));
      chk($sformatf("row%0d_err", i), 32'(err), 32'(vq[i].err));
      chk($sformatf("row%0d_chg", i), 32'(chg_cnt), 32'(vq[i].chg));
`ifdef TRANSPORT_RX_ERR_CNT_EN
      chk($sformatf("row%0d_errcnt", i), 32'(err_cnt), 32'(vq[i].errc));
`endif
    end
    clr = 1'b0;

    // Narrow counter saturates at 3 after five alternating acceptances.
    b_valids = 0;
    b_hold(8'h01, 4); b_hold(8'h02, 4); b_hold(8'h01, 4); b_hold(8'h02, 4); b_hold(8'h01, 4);
    $display("b_alt valids=%0d code=%0d chg=%0d", b_valids, b_code, b_chg_cnt);
    chk("b_alt_valids", 32'(b_valids), 5);
    chk("b_alt_chg", 32'(b_chg_cnt), 3);
    chk("b_alt_code", 32'(b_code), 1);
    chk("b_alt_locked", 32'(b_locked), 1);
    chk("b_alt_err", 32'(b_err), 0);

    // clr on the same edge as an acceptance wins.
    b_data = 8'h02;
    step();
    step();
    chk("b_pre_valid", 32'(b_valid), 0);
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    $display("b_clr_accept valid=%0b code=%0d onehot=%02h chg=%0d", b_valid, b_code, b_onehot, b_chg_cnt);
    chk("b_clr_valid", 32'(b_valid), 1);
    chk("b_clr_code", 32'(b_code), 2);
    chk("b_clr_onehot", 32'(b_onehot), 32'h02);
    chk("b_clr_chg", 32'(b_chg_cnt), 0);
    b_valids = 0;
    b_hold(8'h01, 3);
    $display("b_after_clr valids=%0d chg=%0d", b_valids, b_chg_cnt);
    chk("b_after_clr_valids", 32'(b_valids), 1);
    chk("b_after_clr_chg", 32'(b_chg_cnt), 1);
`ifdef TRANSPORT_RX_ERR_CNT_EN
    chk("b_errcnt", 32'(b_err_cnt), 0);
`endif

    // Reset in the middle of qualification (cnt = 2) aborts immediately.
    data = 8'h06;
    step();
    step();
    step();
    chk("preabort_code", 32'(code), 4);
    chk("preabort_valid", 32'(valid), 0);
    rst = 1'b0;
    #1;
    $display("abort code=%0d onehot=%02h valid=%0b locked=%0b err=%0b chg=%0d", code, onehot, valid, locked, err, chg_cnt);
    chk("abort_code", 32'(code), 0);
    chk("abort_onehot", 32'(onehot), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_locked", 32'(locked), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_b_code", 32'(b_code), 0);
    chk("abort_b_chg", 32'(b_chg_cnt), 0);
    #3;
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      $display("requal edge=%0d valid=%0b code=%0d", k, valid, code);
      chk($sformatf("requal%0d_valid", k), 32'(valid), 0);
      chk($sformatf("requal%0d_code", k), 32'(code), 0);
    end
    step();
    $display("requal edge=5 valid=%0b code=%0d onehot=%02h chg=%0d", valid, code, onehot, chg_cnt);
    chk("requal5_valid", 32'(valid), 1);
    chk("requal5_code", 32'(code), 6);
    chk("requal5_onehot", 32'(onehot), 32'h20);
    chk("requal5_chg", 32'(chg_cnt), 1);
`ifdef TRANSPORT_RX_ERR_CNT_EN
    chk("requal5_errcnt", 32'(err_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
